// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: TX serialiser and RX deserialiser on one baud divider.
// Ports: clk, rst_n, start, txin, tx, rx, rxout, rxdone, txdone (+frame_err if UART_FRAME_ERR_EN).
module uart_core #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] txin,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rxout,
  output logic       rxdone,
  output logic       txdone
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD
  } rx_st_t;

  tx_st_t        r_tx_st, w_tx_ns;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt;
  logic [7:0]    r_tx_sh, w_tx_sh;
  logic [2:0]    r_tx_idx, w_tx_idx;
  logic          r_txdone, w_txdone;
  logic          w_tx_end;

  rx_st_t        r_rx_st, w_rx_ns;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt;
  logic [7:0]    r_rx_sh, w_rx_sh;
  logic [2:0]    r_rx_idx, w_rx_idx;
  logic [7:0]    r_rxout, w_rxout;
  logic          r_rxdone, w_rxdone;
  logic          r_rx_s1, r_rx_s2;
  logic          w_rx_end, w_rx_half;
`ifdef UART_FRAME_ERR_EN
  logic          r_ferr, w_ferr;
  assign frame_err = r_ferr;
`endif

  assign w_tx_end  = (r_tx_cnt == CW'(CPB - 1));
  assign w_rx_end  = (r_rx_cnt == CW'(CPB - 1));
  assign w_rx_half = (r_rx_cnt == CW'(CPB / 2 - 1));

  assign txdone = r_txdone;
  assign rxdone = r_rxdone;
  assign rxout  = r_rxout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_sh  <= '0;
      r_tx_idx <= '0;
      r_txdone <= 1'b0;
    end else begin
      r_tx_st  <= w_tx_ns;
      r_tx_cnt <= w_tx_cnt;
      r_tx_sh  <= w_tx_sh;
      r_tx_idx <= w_tx_idx;
      r_txdone <= w_txdone;
    end
  end

  always_comb begin
    w_tx_ns  = r_tx_st;
    w_tx_cnt = r_tx_cnt + 1'b1;
    w_tx_sh  = r_tx_sh;
    w_tx_idx = r_tx_idx;
    w_txdone = 1'b0;
    tx       = 1'b1;
    case (r_tx_st)
      TX_IDLE: begin
        w_tx_cnt = '0;
        if (start) begin
          w_tx_ns  = TX_START;
          w_tx_sh  = txin;
          w_tx_idx = '0;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (w_tx_end) begin
          w_tx_ns  = TX_DATA;
          w_tx_cnt = '0;
        end
      end
      TX_DATA: begin
        tx = r_tx_sh[0];
        if (w_tx_end) begin
          w_tx_cnt = '0;
          w_tx_sh  = {1'b0, r_tx_sh[7:1]};
          w_tx_idx = r_tx_idx + 1'b1;
          if (r_tx_idx == 3'd7) w_tx_ns = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_tx_end) begin
          w_tx_ns  = TX_IDLE;
          w_tx_cnt = '0;
          w_txdone = 1'b1;
        end
      end
      default: w_tx_ns = TX_IDLE;
    endcase
  end

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_sh  <= '0;
      r_rx_idx <= '0;
      r_rxout  <= '0;
      r_rxdone <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      r_ferr   <= 1'b0;
`endif
    end else begin
      r_rx_s1  <= rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_st  <= w_rx_ns;
      r_rx_cnt <= w_rx_cnt;
      r_rx_sh  <= w_rx_sh;
      r_rx_idx <= w_rx_idx;
      r_rxout  <= w_rxout;
      r_rxdone <= w_rxdone;
`ifdef UART_FRAME_ERR_EN
      r_ferr   <= w_ferr;
`endif
    end
  end

  always_comb begin
    w_rx_ns  = r_rx_st;
    w_rx_cnt = r_rx_cnt + 1'b1;
    w_rx_sh  = r_rx_sh;
    w_rx_idx = r_rx_idx;
    w_rxout  = r_rxout;
    w_rxdone = 1'b0;
`ifdef UART_FRAME_ERR_EN
    w_ferr   = 1'b0;
`endif
    case (r_rx_st)
      RX_IDLE: begin
        w_rx_cnt = '0;
        if (!r_rx_s2) w_rx_ns = RX_START;
      end
      RX_START: begin
        // Half-bit delay puts every later sample at mid-bit.
        if (w_rx_half) begin
          w_rx_cnt = '0;
          w_rx_idx = '0;
          w_rx_ns  = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt = '0;
          w_rx_sh  = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_idx = r_rx_idx + 1'b1;
          if (r_rx_idx == 3'd7) w_rx_ns = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_end) begin
          w_rx_cnt = '0;
          w_rx_ns  = RX_IDLE;
`ifdef UART_FRAME_ERR_EN
          if (r_rx_s2) begin
            w_rxout  = r_rx_sh;
            w_rxdone = 1'b1;
          end else begin
            w_ferr  = 1'b1;
            w_rx_ns = RX_HOLD;
          end
`else
          w_rxout  = r_rx_sh;
          w_rxdone = 1'b1;
`endif
        end
      end
      RX_HOLD: begin
        // Broken frame: wait for the line to return high before re-arming.
        w_rx_cnt = '0;
        if (r_rx_s2) w_rx_ns = RX_IDLE;
      end
      default: w_rx_ns = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// Loopback scoreboard bench for uart_core.
// Bytes are queued when sent and checked when rxdone fires.
module tb_uart_core;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] txin;
  logic       tx;
  logic       w_rx;
  logic [7:0] rxout;
  logic       rxdone;
  logic       txdone;

  logic       r_lb;
  logic       r_rx_drv;

  int         n_cmp;
  int         n_err;
  int         cyc;
  int         n_rx;
  int         n_tx;
  int         last_rx;
  int         wide_rx;
  int         wide_tx;
  logic       p_rx;
  logic       p_tx;
  logic [31:0] m_exp;
  logic [7:0] q[$];

  assign w_rx = r_lb ? tx : r_rx_drv;

  uart_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .txin   (txin),
    .tx     (tx),
    .rx     (w_rx),
    .rxout  (rxout),
    .rxdone (rxdone),
    .txdone (txdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  initial begin
    n_rx = 0; n_tx = 0; last_rx = 0;
    wide_rx = 0; wide_tx = 0;
    p_rx = 1'b0; p_tx = 1'b0;
  end

  always @(negedge clk) begin
    if (rxdone) begin
      n_rx++;
      last_rx = cyc;
      m_exp = (q.size() > 0) ?
              32'(q.pop_front()) : 32'hDEAD;
      chk("rxout", 32'(rxout), m_exp);
    end
    if (txdone) n_tx++;
    if (rxdone && p_rx) wide_rx++;
    if (txdone && p_tx) wide_tx++;
    p_rx = rxdone;
    p_tx = txdone;
  end

  // Call at a negedge; returns at the negedge after the start edge.
  task automatic kick(input logic [7:0] b, input bit push);
    txin  = b;
    start = 1'b1;
    if (push) q.push_back(b);
    @(negedge clk);
  endtask

  // Walks one frame from offset 0; ends at the negedge showing txdone.
  task automatic watch(input logic [7:0] b, input bit bits);
    int off;
    int rx0;
    int k;
    logic [9:0] fb;
    fb  = {1'b1, b, 1'b0};
    rx0 = n_rx;
    for (off = 0; off <= 1100; off++) begin
      if (bits) begin
        if (off == 0 || off == 103)
          chk("start_lo", 32'(tx), 32'(0));
        if (off % 104 == 52) begin
          k = off / 104;
          chk($sformatf("bit%0d", k),
              32'(tx), 32'(fb[k]));
        end
      end
      if (txdone) break;
      @(negedge clk);
    end
    chk("tx_len", off, 1040);
    chk("rx_cnt", n_rx - rx0, 1);
    chk("rx_lead",
        32'((cyc - last_rx) >= 40 && (cyc - last_rx) <= 60),
        32'(1));
  endtask

  initial begin
    logic [7:0] b;
    int rx0;
    int tx0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    txin  = '0;
    r_lb  = 1'b1;
    r_rx_drv = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_rxout", 32'(rxout), 32'(0));
    chk("rst_rxdone", 32'(rxdone), 32'(0));
    chk("rst_txdone", 32'(txdone), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    kick(8'hA5, 1'b1);
    start = 1'b0;
    txin  = 8'h5A;
    watch(8'hA5, 1'b1);
    repeat (20) @(negedge clk);

    kick(8'h0A, 1'b1);
    watch(8'h0A, 1'b1);
    txin = 8'hC8;
    q.push_back(8'hC8);
    @(negedge clk);
    start = 1'b0;
    watch(8'hC8, 1'b1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(200, 10));
      kick(b, 1'b1);
      start = 1'b0;
      txin  = 8'($urandom);
      watch(b, 1'b0);
      repeat (5) @(negedge clk);
    end

    rx0 = n_rx;
    r_lb = 1'b0;
    r_rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    r_rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch", n_rx - rx0, 0);
    r_lb = 1'b1;
    kick(8'h3C, 1'b1);
    start = 1'b0;
    watch(8'h3C, 1'b1);
    repeat (20) @(negedge clk);

    kick(8'h55, 1'b0);
    start = 1'b0;
    repeat (300) @(negedge clk);
    rx0 = n_rx;
    tx0 = n_tx;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'(1));
    repeat (3) @(negedge clk);
    chk("abort_rxout", 32'(rxout), 32'(0));
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    chk("abort_txdone", n_tx - tx0, 0);
    chk("abort_rxdone", n_rx - rx0, 0);
    kick(8'h96, 1'b1);
    start = 1'b0;
    watch(8'h96, 1'b1);
    repeat (20) @(negedge clk);

    chk("q_empty", q.size(), 0);
    chk("rxdone_w", wide_rx, 0);
    chk("txdone_w", wide_tx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing one clock and one baud divider.
- Transmitter serialises a parallel byte on request. Receiver deserialises the rx line into a byte.
- Sits between the system bus logic and the pins. Verification connects tx directly to rx (loopback).

Parameters:
- CLK_FREQ, 1000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, using integer truncation; 104 at the defaults. Must be at least 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  transmit request, level-sensitive.
- txin  input  8  byte to transmit; sampled when a frame is accepted.
- tx  output  1  serial transmit line; idles high.
- rx  input  1  serial receive line; idles high.
- rxout  output  8  last received byte.
- rxdone  output  1  one-cycle pulse when a byte has been received.
- txdone  output  1  one-cycle pulse when a frame has been fully sent.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: tx=1, rxout=0, rxdone=0, txdone=0. All counters are zeroed and both FSMs return to IDLE.
- Reset mid-frame aborts immediately: tx goes high, and no done pulse is produced for the aborted frame.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks.
- TX FSM states and transitions:
  - IDLE: tx=1. On a clock edge where start=1, latch txin into a shift register, drive tx=0 and go to START.
  - START: after CLKS_PER_BIT clocks, go to DATA.
  - DATA: 8 bits, each lasting CLKS_PER_BIT clocks, shifted out LSB first. Then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks. Then assert txdone for one cycle and return to IDLE.
- TX timing rules:
  - Total frame length is 10*CLKS_PER_BIT clocks.
  - txin changes during a frame do not affect that frame.
  - If start remains high, the next frame begins on the clock after txdone, i.e. one full IDLE cycle. txin is sampled at that point.
- RX FSM states and transitions:
  - IDLE: wait for rx=0, detected via a two-flop synchroniser.
  - START: count CLKS_PER_BIT/2 clocks, then re-sample rx. If rx=1, treat it as a glitch and return to IDLE. If rx=0, go to DATA.
  - DATA: sample rx every CLKS_PER_BIT clocks, i.e. mid-bit. Shift the samples in LSB first, 8 samples in total.
  - STOP: after CLKS_PER_BIT clocks, sample the stop bit. Load rxout with the assembled byte, pulse rxdone for one cycle and return to IDLE.
- RX timing and data rules:
  - rxdone is produced at mid-stop-bit. In loopback it therefore precedes the matching txdone by about CLKS_PER_BIT/2 clocks.
  - rxout holds its value until the next successful reception.
  - The stop-bit value does not suppress rxdone (see optional feature).
  - TX and RX operate independently and concurrently. Simultaneous txdone and rxdone are legal.

Optional Feature:
- Macro: UART_FRAME_ERR_EN.
- When defined:
  - Adds output frame_err (1 bit, reset 0).
  - If the sampled stop bit is 0, rxout is not updated, rxdone is not pulsed, and frame_err pulses for one cycle.
  - The RX FSM then waits in IDLE until rx returns high before accepting a new start bit.
- When undefined:
  - There is no frame_err port.
  - rxout and rxdone are updated regardless of the stop-bit value.

Test Plan:
- Reset: hold rst_n=0 for 5 clocks -> tx=1, rxout=0x00, rxdone=0, txdone=0.
- Single loopback byte (tx tied to rx): start=1, txin=0xA5 ->
  - tx low for the first 104 clocks;
  - data bits 1,0,1,0,0,1,0,1;
  - rxdone pulses with rxout=0xA5;
  - txdone pulses about 52 clocks later, 1040 clocks after the start edge.
- Back-to-back frames: start held high; txin=0x0A, then 0xC8 applied after the first txdone -> two consecutive frames; rxout=0x0A then 0xC8; each done signal is exactly one cycle wide.
- Random loopback: 10 bytes drawn from the range 10..200, sent in loopback -> every rxdone is followed by a txdone, and rxout equals the sent byte each time.
- Glitch rejection: drive rx low for 20 clocks while RX is idle -> no rxdone; a following valid frame carrying 0x3C is received correctly.
- Reset mid-frame: assert rst_n=0 during DATA -> tx=1 immediately and no txdone. After release with start=1, a full frame is sent.
